// File: rtl/cnt_pkg.sv
// Shared constants and state encoding for the display counter sequencer.
// Imported by the interface, tick_gen and counter_seq_ctrl.
package cnt_pkg;

  localparam int CNT_WIDTH    = 8;
  localparam int TERMINAL_DEF = 40;
  localparam int TICK_DIV_DEF = 100_000_000;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Board-control and counter-datapath signals of the sequencer.
// master = sequencer side, slave = board/counter side.
interface counter_seq_ctrl_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
);

  logic             start;
  logic             stop;
  logic             load_req;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] ctr_val;
  logic             ctr_ld;
  logic [WIDTH-1:0] ctr_ld_val;
  logic             ctr_step;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    input  start, stop, load_req,
    input  load_val, ctr_val,
    output ctr_ld, ctr_ld_val, ctr_step,
    output busy, done, tc
  );

  modport slave (
    output start, stop, load_req,
    output load_val, ctr_val,
    input  ctr_ld, ctr_ld_val, ctr_step,
    input  busy, done, tc
  );

endinterface

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Prescaler for the sequencer: counts 0..TICK_DIV-1 while enabled.
// tick is registered and high exactly while the count sits at TICK_DIV-1.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= en && !clr && (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 8-bit display counter: load/run/stop/done FSM.
// COUNTER_SEQ_AUTO_RELOAD_EN: reload and restart at TERMINAL instead of DONE.
module counter_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TERMINAL = TERMINAL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  counter_seq_ctrl_if.master bus
);

  if (TICK_DIV < 2) begin : g_div_chk
    $error("TICK_DIV must be >= 2");
  end
  if (TERMINAL < 0 || TERMINAL >= 2**WIDTH) begin : g_term_chk
    $error("TERMINAL out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [1:0]       state;
  logic [1:0]       nxt;
  logic             clr;
  logic             en;
  logic             ld_n;
  logic             tc_n;
  logic [WIDTH-1:0] ldv_n;

`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic             rl_q;
  logic             rl_n;
  logic             lr_q;
  logic             lr_n;
`endif

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .tick  (bus.ctr_step)
  );

  always_comb begin
    nxt   = state;
    clr   = 1'b0;
    en    = 1'b0;
    ld_n  = 1'b0;
    tc_n  = 1'b0;
    ldv_n = bus.ctr_ld_val;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    rl_n  = 1'b0;
    lr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.load_req) begin
          nxt   = LOAD;
          ld_n  = 1'b1;
          ldv_n = bus.load_val;
        end else if (bus.start) begin
          nxt = RUN;
          clr = 1'b1;
        end
      end
      LOAD: begin
        nxt = IDLE;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
        if (lr_q) begin
          nxt = RUN;
          clr = 1'b1;
        end
`endif
      end
      RUN: begin
        if (bus.load_req) begin
          nxt   = LOAD;
          ld_n  = 1'b1;
          ldv_n = bus.load_val;
        end else if (bus.stop)
          nxt = IDLE;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
        else if (rl_q) begin
          nxt   = LOAD;
          ld_n  = 1'b1;
          ldv_n = reload;
          lr_n  = 1'b1;
        end
`endif
        else if (bus.ctr_val == TERM) begin
          // prescaler is frozen so no step lands on the terminal cycle
          tc_n = 1'b1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
          rl_n = 1'b1;
`else
          nxt  = DONE;
`endif
        end else
          en = 1'b1;
      end
      DONE: begin
        if (bus.load_req) begin
          nxt   = LOAD;
          ld_n  = 1'b1;
          ldv_n = bus.load_val;
        end else if (bus.stop)
          nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      bus.ctr_ld     <= 1'b0;
      bus.ctr_ld_val <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.tc         <= 1'b0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
      reload         <= '0;
      rl_q           <= 1'b0;
      lr_q           <= 1'b0;
`endif
    end else begin
      state          <= nxt;
      bus.ctr_ld     <= ld_n;
      bus.ctr_ld_val <= ldv_n;
      bus.busy       <= (nxt == LOAD) || (nxt == RUN);
      bus.done       <= (nxt == DONE);
      bus.tc         <= tc_n;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
      rl_q           <= rl_n;
      lr_q           <= lr_n;
      if (state == LOAD)
        reload <= bus.ctr_ld_val;
`endif
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with TICK_DIV=4, TERMINAL=5.
// A behavioural counter follows ctr_ld/ctr_step and feeds ctr_val.
module tb_counter_seq_ctrl;
  import cnt_pkg::*;

  localparam int W    = 8;
  localparam int DIV  = 4;
  localparam int TERM = 5;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] cnt   = '0;
  int           total = 0;
  int           bad   = 0;

  counter_seq_ctrl_if #(.WIDTH(W)) bus ();

  counter_seq_ctrl #(
    .WIDTH    (W),
    .TICK_DIV (DIV),
    .TERMINAL (TERM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ctr_ld)
      cnt <= bus.ctr_ld_val;
    else if (bus.ctr_step)
      cnt <= cnt + 1'b1;
  end

  assign bus.ctr_val = cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {19'b0, bus.ctr_ld, bus.ctr_step, bus.busy,
            bus.done, bus.tc, bus.ctr_ld_val};
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    bus.load_req = 1'b1;
    bus.load_val = v;
    cyc();
    bus.load_req = 1'b0;
    chk("ld_strobe", bus.ctr_ld, 1);
    chk("ld_val", bus.ctr_ld_val, v);
    cyc();
    chk("ld_idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.load_req = 1'b0;
    bus.load_val = '0;

    // reset state
    cyc();
    cyc();
    chk("rst_outs", outs(), 0);
    reset = 1'b1;
    cyc();
    chk("idle_outs", outs(), 0);

    // load 3 from IDLE
    bus.load_req = 1'b1;
    bus.load_val = 8'h03;
    cyc();
    bus.load_req = 1'b0;
    bus.load_val = '0;
    chk("t2_ld", bus.ctr_ld, 1);
    chk("t2_ldv", bus.ctr_ld_val, 3);
    chk("t2_busy", bus.busy, 1);
    cyc();
    chk("t2_busy_off", bus.busy, 0);
    chk("t2_ld_off", bus.ctr_ld, 0);
    chk("t2_cnt", cnt, 3);

    // run 3 -> 5
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) cyc();
      chk($sformatf("t3_step%0d", c), bus.ctr_step, (c == 4 || c == 8));
      chk($sformatf("t3_tc%0d", c), bus.tc, (c == 10));
      chk($sformatf("t3_busy%0d", c), bus.busy, (c < 10 || AUTO));
    end
    chk("t3_done", bus.done, !AUTO);
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t3_stop_busy", bus.busy, 0);
    chk("t3_stop_ld", bus.ctr_ld, 0);
`else
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("t3_done_hold", bus.done, 1);
    chk("t3_tc_off", bus.tc, 0);
    chk("t3_done_busy", bus.busy, 0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t3_no_step", bus.ctr_step, 0);
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t3_stop_done", bus.done, 0);
    chk("t3_stop_busy", bus.busy, 0);
`endif

    // start with ctr_val already at TERMINAL
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("t3b_busy", bus.busy, 1);
    chk("t3b_tc0", bus.tc, 0);
    cyc();
    chk("t3b_tc1", bus.tc, 1);
    chk("t3b_step", bus.ctr_step, 0);
    chk("t3b_done", bus.done, !AUTO);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t3b_idle", bus.busy, 0);
    chk("t3b_no_ld", bus.ctr_ld, 0);

    // stop at 4, restart: prescaler must restart from 0
    do_load(3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) cyc();
      chk($sformatf("t4_step%0d", c), bus.ctr_step, (c == 4));
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t4_busy", bus.busy, 0);
    chk("t4_step", bus.ctr_step, 0);
    chk("t4_cnt", cnt, 4);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t4_idle_step", bus.ctr_step, 0);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      chk($sformatf("t4_rstep%0d", c), bus.ctr_step, (c == 4));
      chk("t4_rbusy", bus.busy, 1);
    end
    cyc();
    chk("t4_c5_step", bus.ctr_step, 0);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t4_end_busy", bus.busy, 0);

    // simultaneous load/stop/start in RUN: load wins
    do_load(3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    bus.load_req = 1'b1;
    bus.stop     = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = 8'h01;
    cyc();
    bus.load_req = 1'b0;
    bus.stop     = 1'b0;
    bus.start    = 1'b0;
    bus.load_val = '0;
    chk("t5_ld", bus.ctr_ld, 1);
    chk("t5_ldv", bus.ctr_ld_val, 1);
    chk("t5_busy", bus.busy, 1);
    chk("t5_step", bus.ctr_step, 0);
    cyc();
    chk("t5_idle", bus.busy, 0);
    chk("t5_cnt", cnt, 1);

    // reset mid-RUN, just before a step is due
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("t1_rst_a", outs(), 0);
    cyc();
    chk("t1_rst_b", outs(), 0);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      chk("t1_no_step", bus.ctr_step, 0);
      chk("t1_no_busy", bus.busy, 0);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      chk($sformatf("t1_step%0d", c), bus.ctr_step, (c == 4));
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t1_end_busy", bus.busy, 0);

`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    // auto reload: 2 -> 5, tc, reload 2, resume
    do_load(2);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) cyc();
      chk($sformatf("t6_step%0d", c), bus.ctr_step,
          (c == 4 || c == 8 || c == 12 || c == 19));
      chk($sformatf("t6_tc%0d", c), bus.tc, (c == 14));
      chk($sformatf("t6_ld%0d", c), bus.ctr_ld, (c == 15));
      chk($sformatf("t6_done%0d", c), bus.done, 0);
      chk($sformatf("t6_busy%0d", c), bus.busy, 1);
      if (c == 15) chk("t6_ldv", bus.ctr_ld_val, 2);
    end
    chk("t6_cnt", cnt, 3);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t6_end_busy", bus.busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
